p_shfrot_stage: RTL and testbench

Pipelined issue/result stage wrapping the packed shift/rotate datapath. It accepts packed shift/rotate requests from the decode/dispatch logic over a valid/ready handshake. It decodes the pack width, selects and masks the shift amount, and drives the combinational packed shifter from a registered operand stage. It captures the shifter result in a registered response stage that the writeback logic consumes over a second valid/ready handshake.

---
 rtl/p_shfrot_stage.sv | 150 +++++++++++++++
 tb/tb_p_shfrot_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p_shfrot_stage.sv
// p_shfrot_stage: two-stage issue/result wrapper around the external packed shift/rotate
// datapath. S1 holds decoded operands that drive the shifter; S2 holds the response.
module p_shfrot_stage (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [2:0]  req_pw,
   input  logic        req_imm_sel,
   input  logic [4:0]  req_imm,
   input  logic [31:0] crs1,
   input  logic [31:0] crs2,
   output logic [31:0] sh_crs1,
   output logic [4:0]  sh_shamt,
   output logic [4:0]  sh_pw,
   output logic        sh_shift,
   output logic        sh_rotate,
   output logic        sh_left,
   output logic        sh_right,
   input  logic [31:0] sh_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_trap
);

   localparam int unsigned XLEN = 32;

   // Request decode
   logic [4:0] dec_pw;
   logic [4:0] dec_mask;
   logic       dec_ill;
   logic [4:0] raw_shamt;
   logic       unused_crs2;

   always_comb begin
      dec_pw   = 5'b00000;
      dec_mask = 5'h00;
      dec_ill  = 1'b0;
      case (req_pw)
         3'd0:    begin dec_pw = 5'b00001; dec_mask = 5'h1f; end
         3'd1:    begin dec_pw = 5'b00010; dec_mask = 5'h0f; end
         3'd2:    begin dec_pw = 5'b00100; dec_mask = 5'h07; end
         3'd3:    begin dec_pw = 5'b01000; dec_mask = 5'h03; end
         3'd4:    begin dec_pw = 5'b10000; dec_mask = 5'h01; end
         default: dec_ill = 1'b1;
      endcase
   end

   assign raw_shamt   = req_imm_sel ? req_imm : crs2[4:0];
   assign unused_crs2 = ^crs2[31:5];

   // Pipeline state
   logic            s1_v_q,     s1_v_d;
   logic [XLEN-1:0] s1_crs1_q,  s1_crs1_d;
   logic [4:0]      s1_pw_q,    s1_pw_d;
   logic [1:0]      s1_op_q,    s1_op_d;
   logic            s1_ill_q,   s1_ill_d;
   logic [4:0]      s1_shamt_q, s1_shamt_d;

   logic            rsp_valid_q,  rsp_valid_d;
   logic [XLEN-1:0] rsp_result_q, rsp_result_d;
   logic            rsp_trap_q,   rsp_trap_d;

   logic s1_adv;
   logic req_acc;

   assign s1_adv    = s1_v_q && (!rsp_valid_q || rsp_ready);
   assign req_ready = !flush && (!s1_v_q || s1_adv);
   assign req_acc   = req_valid && req_ready;

   always_comb begin
      s1_v_d     = s1_v_q;
      s1_crs1_d  = s1_crs1_q;
      s1_pw_d    = s1_pw_q;
      s1_op_d    = s1_op_q;
      s1_ill_d   = s1_ill_q;
      s1_shamt_d = s1_shamt_q;
      if (flush) begin
         s1_v_d = 1'b0;
      end else if (req_acc) begin
         s1_v_d     = 1'b1;
         s1_crs1_d  = crs1;
         s1_pw_d    = dec_pw;
         s1_op_d    = req_op;
         s1_ill_d   = dec_ill;
         s1_shamt_d = raw_shamt & dec_mask;
      end else if (s1_adv) begin
         s1_v_d = 1'b0;
      end
   end

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_trap_d   = rsp_trap_q;
      if (flush) begin
         rsp_valid_d = 1'b0;
      end else if (s1_adv) begin
         rsp_valid_d  = 1'b1;
         rsp_result_d = s1_ill_q ? '0 : sh_result;
         rsp_trap_d   = s1_ill_q;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         s1_v_q       <= 1'b0;
         s1_crs1_q    <= '0;
         s1_pw_q      <= '0;
         s1_op_q      <= '0;
         s1_ill_q     <= 1'b0;
         s1_shamt_q   <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_trap_q   <= 1'b0;
      end else begin
         s1_v_q       <= s1_v_d;
         s1_crs1_q    <= s1_crs1_d;
         s1_pw_q      <= s1_pw_d;
         s1_op_q      <= s1_op_d;
         s1_ill_q     <= s1_ill_d;
         s1_shamt_q   <= s1_shamt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_trap_q   <= rsp_trap_d;
      end
   end

   // Shifter inputs stay at zero unless a legal op sits in S1, keeping the datapath quiet.
   logic sh_drive;
   assign sh_drive  = s1_v_q && !s1_ill_q;

   assign sh_crs1   = sh_drive ? s1_crs1_q  : '0;
   assign sh_shamt  = sh_drive ? s1_shamt_q : '0;
   assign sh_pw     = sh_drive ? s1_pw_q    : '0;
   assign sh_shift  = sh_drive && !s1_op_q[1];
   assign sh_rotate = sh_drive &&  s1_op_q[1];
   assign sh_left   = sh_drive &&  s1_op_q[0];
   assign sh_right  = sh_drive && !s1_op_q[0];

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_trap   = rsp_trap_q;

endmodule

// File: tb/tb_p_shfrot_stage.sv
// Scoreboard bench for p_shfrot_stage: a bit-level shifter model closes the datapath loop and an
// arithmetic lane model predicts every response.
module tb_p_shfrot_stage;

   logic        g_clk = 1'b0;
   logic        g_resetn, flush, req_valid, req_ready;
   logic [1:0]  req_op;
   logic [2:0]  req_pw;
   logic        req_imm_sel;
   logic [4:0]  req_imm;
   logic [31:0] crs1, crs2, sh_crs1, sh_result, rsp_result;
   logic [4:0]  sh_shamt, sh_pw;
   logic        sh_shift, sh_rotate, sh_left, sh_right;
   logic        rsp_valid, rsp_ready, rsp_trap;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic        trap;
      logic [31:0] result;
   } exp_t;
   exp_t sb_q[$];

   always #5 g_clk = ~g_clk;

   p_shfrot_stage dut (
      .g_clk      (g_clk),
      .g_resetn   (g_resetn),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_pw     (req_pw),
      .req_imm_sel(req_imm_sel),
      .req_imm    (req_imm),
      .crs1       (crs1),
      .crs2       (crs2),
      .sh_crs1    (sh_crs1),
      .sh_shamt   (sh_shamt),
      .sh_pw      (sh_pw),
      .sh_shift   (sh_shift),
      .sh_rotate  (sh_rotate),
      .sh_left    (sh_left),
      .sh_right   (sh_right),
      .sh_result  (sh_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_trap   (rsp_trap)
   );

   // Bit-by-bit lane shifter driven from the DUT's sh_* outputs.
   function automatic logic [31:0] shifter_model(logic [31:0] x, logic [4:0] pw, logic [4:0] s,
                                                 logic rot, logic left);
      logic [31:0] r;
      int w;
      w = 0;
      r = '0;
      for (int k = 0; k < 5; k++) if (pw[k]) w = 32 >> k;
      if (w == 0) return r;
      for (int b = 0; b < 32; b++) begin
         int base, off, src;
         base = (b / w) * w;
         off  = b % w;
         src  = left ? off - int'(s) : off + int'(s);
         if (rot) src = ((src % w) + w) % w;
         if (src >= 0 && src < w) r[b] = x[base + src];
      end
      return r;
   endfunction

   assign sh_result = shifter_model(sh_crs1, sh_pw, sh_shamt, sh_rotate, sh_left);

   // Reference: per-lane arithmetic straight from the request fields.
   function automatic exp_t ref_model(logic [1:0] op, logic [2:0] pw, logic sel, logic [4:0] imm,
                                      logic [31:0] c2, logic [31:0] c1);
      exp_t e;
      longint unsigned w, amt, lmod, v, o, acc, x;
      e.trap   = 1'b0;
      e.result = '0;
      if (pw > 3'd4) begin
         e.trap = 1'b1;
         return e;
      end
      w    = 64'd32 >> pw;
      lmod = 64'd1 << w;
      amt  = (sel ? {59'd0, imm} : {59'd0, c2[4:0]}) % w;
      x    = {32'd0, c1};
      acc  = 0;
      for (int l = 0; l < 32 / int'(w); l++) begin
         v = (x >> (l * w)) % lmod;
         case (op)
            2'b00:   o = v / (64'd1 << amt);
            2'b01:   o = (v * (64'd1 << amt)) % lmod;
            2'b10:   o = ((v >> amt) | (v << (w - amt))) % lmod;
            default: o = ((v << amt) | (v >> (w - amt))) % lmod;
         endcase
         acc = acc | (o << (l * w));
      end
      e.result = acc[31:0];
      return e;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: handshakes complete at the next rising edge; inputs are stable at the falling edge.
   always @(negedge g_clk) begin
      exp_t e;
      logic ok;
      int   w;
      if (rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got result 0x%08h trap %0b, expected none",
                     rsp_result, rsp_trap);
         end else begin
            e = sb_q.pop_front();
            check("rsp_result", rsp_result, e.result);
            check("rsp_trap", {31'd0, rsp_trap}, {31'd0, e.trap});
         end
      end
      if (req_valid && req_ready && g_resetn)
         sb_q.push_back(ref_model(req_op, req_pw, req_imm_sel, req_imm, crs2, crs1));
      if (flush || !g_resetn) sb_q.delete();
      if (g_resetn) begin
         if (sh_pw == 5'd0) begin
            ok = (sh_crs1 == 32'd0) && (sh_shamt == 5'd0) &&
                 !(sh_shift || sh_rotate || sh_left || sh_right);
         end else begin
            w = 0;
            for (int k = 0; k < 5; k++) if (sh_pw[k]) w = 32 >> k;
            ok = $onehot(sh_pw) && (int'(sh_shamt) < w) &&
                 (sh_shift != sh_rotate) && (sh_left != sh_right);
         end
         check("sh_drive_ok", {31'd0, ok}, 32'd1);
      end
   end

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   task automatic drive_req(logic [1:0] op, logic [2:0] pw, logic sel, logic [4:0] imm,
                            logic [31:0] c2, logic [31:0] c1);
      req_valid   = 1'b1;
      req_op      = op;
      req_pw      = pw;
      req_imm_sel = sel;
      req_imm     = imm;
      crs2        = c2;
      crs1        = c1;
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_sh_pw"}, {27'd0, sh_pw}, 32'd0);
      check({tag, "_sh_crs1"}, sh_crs1, 32'd0);
      check({tag, "_sh_flags"}, {28'd0, sh_shift, sh_rotate, sh_left, sh_right}, 32'd0);
      check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, "_rsp_result"}, rsp_result, 32'd0);
      check({tag, "_rsp_trap"}, {31'd0, rsp_trap}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      g_resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      req_op = '0; req_pw = '0; req_imm_sel = 1'b0; req_imm = '0; crs1 = '0; crs2 = '0;
      tick(); tick();
      g_resetn = 1'b1;
      @(negedge g_clk);
      check_reset_outputs("por");

      // Rotate left 8-bit by immediate 1
      tick();
      drive_req(2'b11, 3'd2, 1'b1, 5'd1, 32'h0, 32'h80402010);
      @(negedge g_clk);
      check("rol8_req_ready", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      @(negedge g_clk);
      check("rol8_rsp_valid_early", {31'd0, rsp_valid}, 32'd0);
      check("rol8_sh_pw", {27'd0, sh_pw}, 32'h04);
      check("rol8_sh_shamt", {27'd0, sh_shamt}, 32'd1);
      tick();
      @(negedge g_clk);
      check("rol8_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("rol8_result", rsp_result, 32'h01804020);

      // Shift right 16-bit by register amount 0x13 -> masked to 3
      tick();
      drive_req(2'b00, 3'd1, 1'b0, 5'd0, 32'h00000013, 32'hF000F000);
      tick();
      req_valid = 1'b0;
      @(negedge g_clk);
      check("srl16_sh_shamt", {27'd0, sh_shamt}, 32'd3);
      tick();
      @(negedge g_clk);
      check("srl16_result", rsp_result, 32'h1E001E00);

      // Illegal width code
      tick();
      drive_req(2'b01, 3'd5, 1'b1, 5'd7, 32'h0, 32'hDEADBEEF);
      tick();
      req_valid = 1'b0;
      @(negedge g_clk);
      check("ill_sh_pw", {27'd0, sh_pw}, 32'd0);
      check("ill_sh_crs1", sh_crs1, 32'd0);
      tick();
      @(negedge g_clk);
      check("ill_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("ill_trap", {31'd0, rsp_trap}, 32'd1);
      check("ill_result", rsp_result, 32'd0);

      // Backpressure: two held, third stalls, then drains in order
      tick();
      rsp_ready = 1'b0;
      drive_req(2'b01, 3'd0, 1'b1, 5'd4, 32'h0, 32'h12345678);
      @(negedge g_clk);
      check("bp_ready_a", {31'd0, req_ready}, 32'd1);
      tick();
      drive_req(2'b10, 3'd3, 1'b0, 5'd0, 32'h00000005, 32'hA5A5A5A5);
      @(negedge g_clk);
      check("bp_ready_b", {31'd0, req_ready}, 32'd1);
      tick();
      drive_req(2'b11, 3'd4, 1'b1, 5'd3, 32'h0, 32'h5555AAAA);
      @(negedge g_clk);
      check("bp_ready_c_stall", {31'd0, req_ready}, 32'd0);
      tick();
      @(negedge g_clk);
      check("bp_ready_c_stall2", {31'd0, req_ready}, 32'd0);
      tick();
      rsp_ready = 1'b1;
      @(negedge g_clk);
      check("bp_ready_comb", {31'd0, req_ready}, 32'd1);
      check("bp_rsp_valid_a", {31'd0, rsp_valid}, 32'd1);
      tick();
      req_valid = 1'b0;
      @(negedge g_clk);
      check("bp_rsp_valid_b", {31'd0, rsp_valid}, 32'd1);
      tick();
      @(negedge g_clk);
      check("bp_rsp_valid_c", {31'd0, rsp_valid}, 32'd1);
      tick();
      @(negedge g_clk);
      check("bp_rsp_drained", {31'd0, rsp_valid}, 32'd0);
      check("bp_ready_back", {31'd0, req_ready}, 32'd1);
      check("bp_sb_empty", sb_q.size(), 32'd0);

      // Flush with both stages full
      tick();
      rsp_ready = 1'b0;
      drive_req(2'b01, 3'd2, 1'b1, 5'd2, 32'h0, 32'h0F0F0F0F);
      tick();
      drive_req(2'b00, 3'd0, 1'b1, 5'd1, 32'h0, 32'h80000000);
      tick();
      drive_req(2'b11, 3'd1, 1'b1, 5'd5, 32'h0, 32'hCAFEF00D);
      flush = 1'b1;
      @(negedge g_clk);
      check("flush_req_ready", {31'd0, req_ready}, 32'd0);
      tick();
      flush = 1'b0;
      req_valid = 1'b0;
      @(negedge g_clk);
      check("flush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("flush_s1_empty", {27'd0, sh_pw}, 32'd0);
      check("flush_sh_crs1", sh_crs1, 32'd0);
      tick();
      rsp_ready = 1'b1;
      repeat (3) tick();

      // Reset with an op in S1 and a stale nonzero result in S2
      rsp_ready = 1'b0;
      drive_req(2'b01, 3'd0, 1'b1, 5'd8, 32'h0, 32'h000000FF);
      tick();
      req_valid = 1'b0;
      @(negedge g_clk);
      check("rst_s1_loaded", {27'd0, sh_pw}, 32'h01);
      tick();
      g_resetn = 1'b0;
      tick();
      g_resetn = 1'b1;
      @(negedge g_clk);
      check_reset_outputs("midrst");
      tick();
      rsp_ready = 1'b1;
      repeat (3) tick();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         req_valid   = ($urandom_range(0, 9) < 7);
         req_op      = 2'($urandom);
         req_pw      = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                   : 3'($urandom_range(0, 4));
         req_imm_sel = 1'($urandom);
         req_imm     = 5'($urandom);
         crs1        = $urandom;
         crs2        = $urandom;
         rsp_ready   = ($urandom_range(0, 9) < 7);
         flush       = ($urandom_range(0, 49) == 0);
         g_resetn    = ($urandom_range(0, 199) != 0);
         tick();
      end

      req_valid = 1'b0;
      flush     = 1'b0;
      g_resetn  = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
      @(negedge g_clk);
      check("drain_sb_empty", sb_q.size(), 32'd0);
      check("drain_rsp_valid", {31'd0, rsp_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
